// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        KILL,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Instruction-fetch front end: owns the PC, fetches over req/ack, and hands
// instructions to decode over valid/ready. Redirects squash in-flight fetches.
module fetch_pc
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_pc_q, pend_pc_d;
    word_t        if_pc_q, if_pc_d;
    word_t        if_instr_q, if_instr_d;
    logic         if_valid_q, if_valid_d;
    word_t        target;

    assign target = redirect_target & 32'hFFFF_FFFC;

    assign imem_req  = (state_q == REQ) || (state_q == KILL);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        pc_d = target;
                    end else begin
                        // Address must stay stable until the ack, so park the target.
                        pend_pc_d = target;
                        state_d   = KILL;
                    end
                end else if (imem_ack) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = (pc_q + 32'd4) & 32'hFFFF_FFFC;
                    state_d    = HOLD;
                end
            end
            KILL: begin
                if (redirect_valid) begin
                    pend_pc_d = target;
                end
                if (imem_ack) begin
                    pc_d    = redirect_valid ? target : pend_pc_q;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            if_pc_q    <= RESET_PC;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed cycle table plus randomized run
// against a transaction-level reference model.
module tb_fetch_pc;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    int checks = 0;
    int errors = 0;

    fetch_pc dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_ready        (if_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] target;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic ready,
                                logic redir, logic [31:0] target, logic e_req,
                                logic [31:0] e_addr, logic e_valid, logic [31:0] e_pc,
                                logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready;
        v.redir = redir; v.target = target; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic ready, input logic redir, input logic [31:0] target);
        reset           = rst;
        imem_ack        = ack;
        imem_rdata      = rdata;
        if_ready        = ready;
        redirect_valid  = redir;
        redirect_target = target;
    endtask

    // Reference model: a fetcher is either not yet started, waiting on memory
    // (possibly for a fetch that must be thrown away), or holding an instruction.
    bit    m_started;
    bit    m_holding;
    bit    m_stale;
    word_t m_fetch;
    word_t m_resume;
    word_t m_ipc;
    word_t m_instr;

    function automatic word_t align(input word_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_step(input logic rst, input logic ack, input word_t rdata,
                              input logic ready, input logic redir, input word_t tgt);
        if (rst) begin
            m_started = 0; m_holding = 0; m_stale = 0;
            m_fetch = RESET_PC; m_resume = RESET_PC; m_ipc = RESET_PC; m_instr = 0;
        end else if (!m_started) begin
            m_started = 1;
            if (redir) m_fetch = align(tgt);
        end else if (m_holding) begin
            if (redir) m_fetch = align(tgt);
            if (redir || ready) m_holding = 0;
        end else if (m_stale) begin
            if (redir) m_resume = align(tgt);
            if (ack) begin
                m_fetch = m_resume;
                m_stale = 0;
            end
        end else if (redir) begin
            if (ack) m_fetch = align(tgt);
            else begin
                m_stale  = 1;
                m_resume = align(tgt);
            end
        end else if (ack) begin
            m_holding = 1;
            m_ipc     = m_fetch;
            m_instr   = rdata;
            m_fetch   = m_fetch + 32'd4;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'h0, imem_req}, 32'h0);
        chk("reset_addr", imem_addr, 32'h0000_3000);
        chk("reset_valid", {31'h0, if_valid}, 32'h0);
        chk("reset_pc", if_pc, 32'h0000_3000);
        chk("reset_instr", if_instr, 32'h0);

        //            rst ack rdata         rdy rdr target         req addr          v  pc            instr
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_3000, 0, 32'h3000,     32'h0));
        vecs.push_back(mk(0, 1, 32'h2408_0001, 0, 0, 32'h0,         1, 32'h0000_3000, 0, 32'h3000,     32'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,         0, 32'h0000_3004, 1, 32'h3000,     32'h2408_0001));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_3004, 1, 32'h3000,     32'h2408_0001));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,         1, 32'h0000_3004, 0, 32'h3000,     32'h2408_0001));
        vecs.push_back(mk(0, 1, 32'h1111_1111, 0, 0, 32'h0,         1, 32'h0000_3004, 0, 32'h3000,     32'h2408_0001));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_3008, 1, 32'h3004,     32'h1111_1111));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h3103,      1, 32'h0000_3008, 0, 32'h3004,     32'h1111_1111));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_3008, 0, 32'h3004,     32'h1111_1111));
        vecs.push_back(mk(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,         1, 32'h0000_3008, 0, 32'h3004,     32'h1111_1111));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h3200,      1, 32'h0000_3100, 0, 32'h3004,     32'h1111_1111));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h3300,      1, 32'h0000_3100, 0, 32'h3004,     32'h1111_1111));
        vecs.push_back(mk(0, 1, 32'h5555_5555, 0, 0, 32'h0,         1, 32'h0000_3100, 0, 32'h3004,     32'h1111_1111));
        vecs.push_back(mk(0, 1, 32'h2222_2222, 0, 0, 32'h0,         1, 32'h0000_3300, 0, 32'h3004,     32'h1111_1111));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0000_3304, 1, 32'h3300,     32'h2222_2222));
        vecs.push_back(mk(0, 1, 32'h3333_3333, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h3300,     32'h2222_2222));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h3333_3333));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h3333_3333));
        vecs.push_back(mk(0, 1, 32'h7777_7777, 0, 0, 32'h0,         0, 32'h0000_3000, 0, 32'h3000,     32'h0));
        vecs.push_back(mk(0, 1, 32'h4444_4444, 0, 1, 32'h3402,      1, 32'h0000_3000, 0, 32'h3000,     32'h0));
        vecs.push_back(mk(0, 1, 32'h6666_6666, 0, 0, 32'h0,         1, 32'h0000_3400, 0, 32'h3000,     32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_3404, 1, 32'h3400,     32'h6666_6666));

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        foreach (vecs[i]) begin
            chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].e_instr);
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].redir,
                  vecs[i].target);
            @(negedge clk);
        end

        // Randomized run; the first cycle resets both DUT and model into lockstep.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        model_step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_ack, r_rdy, r_rdr;
            logic [31:0] r_data, r_tgt;
            chk("rand_req", {31'h0, imem_req}, {31'h0, m_started && !m_holding});
            chk("rand_addr", imem_addr, m_fetch);
            chk("rand_valid", {31'h0, if_valid}, {31'h0, m_holding});
            chk("rand_pc", if_pc, m_ipc);
            chk("rand_instr", if_instr, m_instr);
            r_rst  = ($urandom_range(0, 99) == 0);
            r_ack  = ($urandom_range(0, 2) == 0);
            r_rdy  = ($urandom_range(0, 1) == 0);
            r_rdr  = ($urandom_range(0, 6) == 0);
            r_data = $urandom;
            r_tgt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
            drive(r_rst, r_ack, r_data, r_rdy, r_rdr, r_tgt);
            model_step(r_rst, r_ack, r_data, r_rdy, r_rdr, r_tgt);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
